seg_scan_decoder: RTL and testbench
===================================

// Module: seg_scan_decoder
// PURPOSE
//  Receive-side companion to the multiplexed 7-segment scan driver in the clock design.
//  Samples the scanned segment and digit-select bus and decodes each segment pattern back to a digit code.
//  Reassembles one complete 8-digit frame per scan pass and hands it off over a valid/ready handshake.
//  Used for on-board self-check and for forwarding the displayed time to a host link.
// PARAMETERS
//  SETTLE_CYC  4          consecutive stable cycles of seg_which AND seg_data required before a sample
//  SCAN_CYC    200001     digit dwell in clk cycles; used only to step through blanked (all-zero) selects
//  STALE_CYC   100000000  watchdog limit in clk cycles (only with SEG_DEC_STALE_EN)
// PORTS
//  clk           in   1   system clock, 100 MHz
//  rst           in   1   synchronous, active-high reset
//  seg_data      in   8   segment pattern; bit7=a..bit1=g, bit0=dp (dp ignored)
//  seg_which     in   8   one-hot digit select; bit7=digit0 (leftmost), bit0=digit7; 8'h00 = blanked
//  frame_digits  out  32  digit n at [31-4n -: 4]; code 0-9, 4'hA='-', 4'hE=blank, 4'hF=invalid
//  blank_mask    out  8   bit7-n set when digit n was blanked in this frame
//  frame_valid   out  1   frame_digits/blank_mask hold a complete, unaccepted frame
//  frame_ready   in   1   consumer accepts on clk edge where frame_valid&&frame_ready
//  code_err      out  1   1-cycle pulse: undecodable pattern or multi-hot seg_which sampled
//  overrun       out  1   1-cycle pulse: completed frame dropped because output still held
//  stale         out  1   no frame completed within STALE_CYC (see CONFIGURATION)
// BEHAVIOUR
//  Reset: all outputs 0; fill mask, working buffer, position pointer, and all counters cleared.
//   Reset takes effect mid-frame; any partial frame is discarded.
//  Settle: settle counter clears on any change of seg_which or seg_data[7:1], otherwise increments.
//   Exactly one sample is taken per stable epoch, when the counter reaches SETTLE_CYC-1.
//   This absorbs the driver's 1-cycle lag of segment data behind select.
//  Sample with one-hot seg_which at index n:
//   - Decode seg_data[7:1]: FC->0, 60->1, DA->2, F2->3, 66->4, B6->5, BE->6, E0->7, FE->8, F6->9, 02->A.
//   - Any other pattern -> F and a code_err pulse.
//   - Write the code into buffer slot n, set fill bit n, and set the position pointer to n.
//  Sample with seg_which==0:
//   - Slot = pointer+1 (mod 8); write code E and set fill and blank bits.
//   - While select stays 0, a dwell counter steps the pointer and blanks the next slot every SCAN_CYC cycles.
//  Multi-hot seg_which: code_err pulses; the sample is discarded and the pointer is unchanged.
//  Frame completion: triggered when slot 7 is written.
//   - If fill==8'hFF, the frame is complete; otherwise it is silently discarded (started mid-scan).
//   - Fill and blank masks clear after slot 7 in either case.
//  Handoff:
//   - Complete frame with frame_valid==0, or with a same-cycle accept: load the outputs and set frame_valid.
//     Latency is 1 cycle after the slot-7 sample.
//   - Complete frame while frame_valid && !frame_ready: keep the old frame, drop the new one, pulse overrun.
//   - frame_valid && frame_ready with no new frame: frame_valid clears on the next edge.
//   - Outputs stay stable while frame_valid is high.
//  Widths: settle counter is $clog2(SETTLE_CYC+1) bits; dwell counter is $clog2(SCAN_CYC+1) bits.
//   The pointer is 3 bits and wraps 7->0.
// CONFIGURATION
//  SEG_DEC_STALE_EN defined:
//   - A watchdog counter clears on each frame completion (complete or discarded) and on rst.
//   - stale sets when the counter reaches STALE_CYC; it clears on the next completion.
//  SEG_DEC_STALE_EN undefined: no watchdog logic; stale is tied to 0.
// TESTING  (override SETTLE_CYC=2, SCAN_CYC=8, STALE_CYC=200)
//  1. Drive one scan of "23-59-55" with 8-cycle dwell per digit, frame_ready=1.
//     -> frame_valid pulses 1 cycle; frame_digits=32'h23A59A55; blank_mask=0.
//  2. Blank digits 0 and 1 (seg_which=0 for 16 cycles after digit 7), then digits 2-7 normal.
//     -> digits[31:24]=8'hEE; blank_mask=8'hC0.
//  3. Hold frame_ready=0 for two full scans.
//     -> first frame held unchanged; overrun pulses once at the second slot-7 sample.
//  4. Send seg_data=8'h12 on digit 3 and seg_which=8'h11 in one epoch.
//     -> code_err pulses twice; digit3=F; no frame from the multi-hot epoch.
//  5. Assert rst in the middle of a scan, then continue scanning.
//     -> frame_valid stays 0 until the first complete scan after reset (partial frame discarded).
//  6. With SEG_DEC_STALE_EN defined, stop scanning.
//     -> stale=1 exactly 200 cycles after the last completion; clears on the next frame.

Source files
------------

// File: rtl/seg_scan_decoder.sv
// Receive-side decoder for a multiplexed 7-segment scan bus: settles, decodes and reassembles 8-digit frames.
// Optional stale-frame watchdog is enabled by defining SEG_DEC_STALE_EN.
module seg_scan_decoder #(
    parameter int SETTLE_CYC = 4,
    parameter int SCAN_CYC   = 200001,
    parameter int STALE_CYC  = 100000000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  seg_data,
    input  logic [7:0]  seg_which,
    output logic [31:0] frame_digits,
    output logic [7:0]  blank_mask,
    output logic        frame_valid,
    input  logic        frame_ready,
    output logic        code_err,
    output logic        overrun,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int DW = $clog2(SCAN_CYC + 1);
    localparam logic [SW-1:0] SETTLE_HIT = SW'(SETTLE_CYC - 1);
    localparam logic [SW-1:0] SETTLE_MAX = SW'(SETTLE_CYC);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYC - 1);
    localparam logic [3:0]    CODE_BLANK = 4'hE;
    localparam logic [3:0]    CODE_BAD   = 4'hF;

    function automatic logic [3:0] decode_seg(input logic [6:0] pat);
        logic [3:0] code;
        case ({pat, 1'b0})
            8'hFC:   code = 4'h0;
            8'h60:   code = 4'h1;
            8'hDA:   code = 4'h2;
            8'hF2:   code = 4'h3;
            8'h66:   code = 4'h4;
            8'hB6:   code = 4'h5;
            8'hBE:   code = 4'h6;
            8'hE0:   code = 4'h7;
            8'hFE:   code = 4'h8;
            8'hF6:   code = 4'h9;
            8'h02:   code = 4'hA;
            default: code = CODE_BAD;
        endcase
        return code;
    endfunction

    function automatic logic is_onehot(input logic [7:0] w);
        return (w != 8'h00) && ((w & (w - 8'h01)) == 8'h00);
    endfunction

    // seg_which bit 7 selects the leftmost digit (slot 0)
    function automatic logic [2:0] onehot_slot(input logic [7:0] w);
        logic [2:0] slot;
        slot = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (w[i]) begin
                slot = 3'(7 - i);
            end
        end
        return slot;
    endfunction

    logic [7:0]    prev_which_r;
    logic [6:0]    prev_seg_r;
    logic [SW-1:0] settle_cnt_r;
    logic [DW-1:0] dwell_cnt_r;
    logic          blank_run_r;
    logic [2:0]    ptr_r;
    logic [7:0]    fill_r;
    logic [7:0]    blank_r;
    logic [3:0]    buf_r [0:7];

    logic [31:0]   frame_digits_r;
    logic [7:0]    blank_mask_r;
    logic          frame_valid_r;
    logic          code_err_r;
    logic          overrun_r;

    logic          changed_s;
    logic          sample_s;
    logic          dwell_step_s;
    logic          wr_en_s;
    logic [2:0]    wr_slot_s;
    logic [3:0]    wr_code_s;
    logic          wr_blank_s;
    logic          err_s;
    logic [7:0]    slot_bit_s;
    logic [7:0]    fill_next_s;
    logic [7:0]    blank_next_s;
    logic          frame_done_s;
    logic          frame_full_s;
    logic [3:0]    buf_next_s [0:7];
    logic [31:0]   frame_next_s;
    logic          unused_dp_s;

    assign unused_dp_s = seg_data[0];

    // Settle detection: one sample per stable epoch, plus blank stepping while select is idle
    always_comb begin
        changed_s    = (seg_which != prev_which_r) || (seg_data[7:1] != prev_seg_r);
        sample_s     = !changed_s && (settle_cnt_r == SETTLE_HIT);
        dwell_step_s = blank_run_r && (seg_which == 8'h00) && !sample_s
                       && (dwell_cnt_r == DWELL_LAST);
    end

    // Select which slot is written this cycle and with what code
    always_comb begin
        wr_en_s    = 1'b0;
        wr_slot_s  = ptr_r;
        wr_code_s  = CODE_BLANK;
        wr_blank_s = 1'b0;
        err_s      = 1'b0;
        if (sample_s) begin
            if (seg_which == 8'h00) begin
                wr_en_s    = 1'b1;
                wr_slot_s  = ptr_r + 3'd1;
                wr_blank_s = 1'b1;
            end else if (is_onehot(seg_which)) begin
                wr_en_s   = 1'b1;
                wr_slot_s = onehot_slot(seg_which);
                wr_code_s = decode_seg(seg_data[7:1]);
                err_s     = (wr_code_s == CODE_BAD);
            end else begin
                err_s = 1'b1;
            end
        end else if (dwell_step_s) begin
            wr_en_s    = 1'b1;
            wr_slot_s  = ptr_r + 3'd1;
            wr_blank_s = 1'b1;
        end else begin
            wr_en_s = 1'b0;
        end
    end

    // Next-state of the working buffer, masks and the assembled frame image
    always_comb begin
        slot_bit_s   = 8'h80 >> wr_slot_s;
        fill_next_s  = fill_r;
        blank_next_s = blank_r;
        for (int i = 0; i < 8; i++) begin
            buf_next_s[i] = buf_r[i];
        end
        if (wr_en_s) begin
            fill_next_s           = fill_r | slot_bit_s;
            blank_next_s          = wr_blank_s ? (blank_r | slot_bit_s) : (blank_r & ~slot_bit_s);
            buf_next_s[wr_slot_s] = wr_code_s;
        end else begin
            fill_next_s = fill_r;
        end
        frame_done_s = wr_en_s && (wr_slot_s == 3'd7);
        frame_full_s = frame_done_s && (fill_next_s == 8'hFF);
        frame_next_s = 32'h0000_0000;
        for (int i = 0; i < 8; i++) begin
            frame_next_s[31 - 4 * i -: 4] = buf_next_s[i];
        end
    end

    // Settle and dwell counters
    always_ff @(posedge clk) begin
        if (rst) begin
            prev_which_r <= 8'h00;
            prev_seg_r   <= 7'h00;
            settle_cnt_r <= '0;
            dwell_cnt_r  <= '0;
            blank_run_r  <= 1'b0;
        end else begin
            prev_which_r <= seg_which;
            prev_seg_r   <= seg_data[7:1];
            if (changed_s) begin
                settle_cnt_r <= '0;
            end else if (settle_cnt_r != SETTLE_MAX) begin
                settle_cnt_r <= settle_cnt_r + SW'(1);
            end else begin
                settle_cnt_r <= settle_cnt_r;
            end
            if (seg_which != 8'h00) begin
                blank_run_r <= 1'b0;
                dwell_cnt_r <= '0;
            end else if (sample_s) begin
                blank_run_r <= 1'b1;
                dwell_cnt_r <= '0;
            end else if (blank_run_r) begin
                dwell_cnt_r <= dwell_step_s ? '0 : dwell_cnt_r + DW'(1);
            end else begin
                dwell_cnt_r <= dwell_cnt_r;
            end
        end
    end

    // Working buffer, fill/blank masks and position pointer
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_r   <= 3'd0;
            fill_r  <= 8'h00;
            blank_r <= 8'h00;
            for (int i = 0; i < 8; i++) begin
                buf_r[i] <= 4'h0;
            end
        end else begin
            if (wr_en_s) begin
                ptr_r <= wr_slot_s;
            end else begin
                ptr_r <= ptr_r;
            end
            fill_r  <= frame_done_s ? 8'h00 : fill_next_s;
            blank_r <= frame_done_s ? 8'h00 : blank_next_s;
            for (int i = 0; i < 8; i++) begin
                buf_r[i] <= buf_next_s[i];
            end
        end
    end

    // Output handoff: a held frame is never overwritten until accepted
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_digits_r <= 32'h0000_0000;
            blank_mask_r   <= 8'h00;
            frame_valid_r  <= 1'b0;
            code_err_r     <= 1'b0;
            overrun_r      <= 1'b0;
        end else begin
            code_err_r <= err_s;
            overrun_r  <= 1'b0;
            if (frame_full_s && (!frame_valid_r || frame_ready)) begin
                frame_digits_r <= frame_next_s;
                blank_mask_r   <= blank_next_s;
                frame_valid_r  <= 1'b1;
            end else if (frame_full_s) begin
                overrun_r <= 1'b1;
            end else if (frame_valid_r && frame_ready) begin
                frame_valid_r <= 1'b0;
            end else begin
                frame_valid_r <= frame_valid_r;
            end
        end
    end

`ifdef SEG_DEC_STALE_EN
    localparam int TW = $clog2(STALE_CYC + 1);
    localparam logic [TW-1:0] STALE_MAX = TW'(STALE_CYC);
    localparam logic [TW-1:0] STALE_HIT = TW'(STALE_CYC - 1);

    logic [TW-1:0] stale_cnt_r;
    logic          stale_r;

    // Watchdog restarts on any slot-7 completion, complete or discarded
    always_ff @(posedge clk) begin
        if (rst) begin
            stale_cnt_r <= '0;
            stale_r     <= 1'b0;
        end else if (frame_done_s) begin
            stale_cnt_r <= '0;
            stale_r     <= 1'b0;
        end else begin
            if (stale_cnt_r != STALE_MAX) begin
                stale_cnt_r <= stale_cnt_r + TW'(1);
            end else begin
                stale_cnt_r <= stale_cnt_r;
            end
            if (stale_cnt_r == STALE_HIT) begin
                stale_r <= 1'b1;
            end else begin
                stale_r <= stale_r;
            end
        end
    end

    assign stale = stale_r;
`else
    localparam int unused_stale_cyc = STALE_CYC;
    assign stale = 1'b0;
`endif

    assign frame_digits = frame_digits_r;
    assign blank_mask   = blank_mask_r;
    assign frame_valid  = frame_valid_r;
    assign code_err     = code_err_r;
    assign overrun      = overrun_r;

endmodule

// File: tb/tb_seg_scan_decoder.sv
// Self-checking bench for seg_scan_decoder: random scans checked against a frame-level reference model.
module tb_seg_scan_decoder;

    localparam int SETTLE = 2;
    localparam int SCAN   = 8;
    localparam int STALE  = 200;
`ifdef SEG_DEC_STALE_EN
    localparam bit STALE_ON = 1'b1;
`else
    localparam bit STALE_ON = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  seg_data;
    logic [7:0]  seg_which;
    logic [31:0] frame_digits;
    logic [7:0]  blank_mask;
    logic        frame_valid;
    logic        frame_ready;
    logic        code_err;
    logic        overrun;
    logic        stale;

    always #5 clk = ~clk;

    seg_scan_decoder #(.SETTLE_CYC(SETTLE), .SCAN_CYC(SCAN), .STALE_CYC(STALE)) dut (
        .clk(clk), .rst(rst), .seg_data(seg_data), .seg_which(seg_which),
        .frame_digits(frame_digits), .blank_mask(blank_mask), .frame_valid(frame_valid),
        .frame_ready(frame_ready), .code_err(code_err), .overrun(overrun), .stale(stale)
    );

    int checks = 0;
    int failures = 0;

    logic [7:0] pat_tbl [0:10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66, 8'hB6,
                                   8'hBE, 8'hE0, 8'hFE, 8'hF6, 8'h02};

    // Observed traffic
    logic [31:0] got_frame_q[$];
    logic [7:0]  got_mask_q[$];
    int          err_seen = 0;
    int          ovr_seen = 0;
    int          valid_cyc = 0;

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid && frame_ready) begin
                got_frame_q.push_back(frame_digits);
                got_mask_q.push_back(blank_mask);
            end
            if (code_err) err_seen++;
            if (overrun) ovr_seen++;
            if (frame_valid) valid_cyc++;
        end
    end

    // Reference model: per-slot digit codes, frame assembled whenever slot 7 is written
    int          m_code[8];
    bit          m_fill[8];
    bit          m_blank[8];
    int          m_ptr;
    logic [7:0]  m_prev_which;
    logic [6:0]  m_prev_data;
    int          exp_err = 0;
    logic [31:0] exp_frame_q[$];
    logic [7:0]  exp_mask_q[$];

    function automatic int model_decode(input logic [7:0] d);
        for (int i = 0; i < 11; i++) begin
            if (pat_tbl[i][7:1] == d[7:1]) return i;
        end
        return 15;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) begin
            m_code[i] = 0; m_fill[i] = 1'b0; m_blank[i] = 1'b0;
        end
        m_ptr = 0;
        m_prev_which = 8'h00;
        m_prev_data = 7'h00;
    endtask

    task automatic model_write(input int slot, input int code, input bit blk);
        bit          full;
        logic [31:0] f;
        logic [7:0]  m;
        m_code[slot] = code; m_fill[slot] = 1'b1; m_blank[slot] = blk; m_ptr = slot;
        if (slot == 7) begin
            full = 1'b1;
            for (int i = 0; i < 8; i++) begin
                full = full & m_fill[i];
                f[31 - 4 * i -: 4] = 4'(m_code[i]);
                m[7 - i] = m_blank[i];
                m_fill[i] = 1'b0;
                m_blank[i] = 1'b0;
            end
            if (full) begin
                exp_frame_q.push_back(f);
                exp_mask_q.push_back(m);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic send_epoch(input logic [7:0] which, input logic [7:0] data, input int dur);
        int slot;
        int code;
        seg_which = which;
        seg_data = data;
        repeat (dur) tick();
        if (dur >= 3 && (which != m_prev_which || data[7:1] != m_prev_data)) begin
            if (which == 8'h00) begin
                for (int k = 0; k < 1 + (dur - 3) / SCAN; k++) model_write((m_ptr + 1) % 8, 14, 1'b1);
            end else if ($countones(which) == 1) begin
                slot = 0;
                for (int b = 0; b < 8; b++) if (which[b]) slot = 7 - b;
                code = model_decode(data);
                if (code == 15) exp_err++;
                model_write(slot, code, 1'b0);
            end else begin
                exp_err++;
            end
        end
        m_prev_which = which;
        m_prev_data = data[7:1];
    endtask

    task automatic send_digit(input int n, input logic [3:0] code);
        send_epoch(8'h80 >> n, pat_tbl[code], 8);
    endtask

    task automatic send_scan(input logic [31:0] digs);
        for (int n = 0; n < 8; n++) send_digit(n, digs[31 - 4 * n -: 4]);
    endtask

    function automatic logic [31:0] rand_scan();
        logic [31:0] d;
        for (int n = 0; n < 8; n++) d[31 - 4 * n -: 4] = 4'($urandom_range(10, 0));
        return d;
    endfunction

    task automatic clear_queues();
        got_frame_q.delete(); got_mask_q.delete();
        exp_frame_q.delete(); exp_mask_q.delete();
    endtask

    task automatic test_reset();
        rst = 1'b1; frame_ready = 1'b1; seg_which = 8'h01; seg_data = 8'hFE;
        repeat (3) tick();
        checks++;
        if ({frame_valid, code_err, overrun, stale} !== 4'b0000) begin
            failures++; $display("FAIL reset_flags: got %b expected 0000", {frame_valid, code_err, overrun, stale});
        end
        checks++;
        if ({frame_digits, blank_mask} !== 40'h0) begin
            failures++; $display("FAIL reset_data: got %h expected 0", {frame_digits, blank_mask});
        end
        rst = 1'b0;
        model_reset();
        clear_queues();
        send_epoch(8'h01, 8'hFE, 8);
        checks++;
        if (got_frame_q.size() != 0 || frame_valid !== 1'b0) begin
            failures++; $display("FAIL reset_partial: got %0d frames expected 0", got_frame_q.size());
        end
    endtask

    task automatic test_basic();
        int vc0;
        clear_queues();
        vc0 = valid_cyc;
        send_scan(32'h23A59A55);
        checks++;
        if (got_frame_q.size() != 1) begin
            failures++; $display("FAIL basic_count: got %0d expected 1", got_frame_q.size());
        end else begin
            checks++;
            if (got_frame_q[0] !== 32'h23A59A55 || got_mask_q[0] !== 8'h00) begin
                failures++; $display("FAIL basic_frame: got %h/%h expected 23a59a55/00", got_frame_q[0], got_mask_q[0]);
            end
        end
        checks++;
        if (valid_cyc - vc0 != 1) begin
            failures++; $display("FAIL basic_pulse: got %0d expected 1", valid_cyc - vc0);
        end
    endtask

    task automatic test_blank();
        logic [31:0] d;
        clear_queues();
        d = rand_scan();
        send_digit(7, 4'($urandom_range(10, 0)));
        send_epoch(8'h00, 8'h00, 16);
        for (int n = 2; n < 8; n++) send_digit(n, d[31 - 4 * n -: 4]);
        checks++;
        if (got_frame_q.size() != 1 || exp_frame_q.size() != 1) begin
            failures++; $display("FAIL blank_count: got %0d expected 1", got_frame_q.size());
        end else begin
            checks++;
            if (got_frame_q[0] !== exp_frame_q[0] || got_frame_q[0][31:24] !== 8'hEE) begin
                failures++; $display("FAIL blank_frame: got %h expected %h", got_frame_q[0], exp_frame_q[0]);
            end
            checks++;
            if (got_mask_q[0] !== 8'hC0) begin
                failures++; $display("FAIL blank_mask: got %h expected c0", got_mask_q[0]);
            end
        end
    endtask

    task automatic test_overrun();
        int o0;
        logic [31:0] held;
        clear_queues();
        o0 = ovr_seen;
        frame_ready = 1'b0;
        send_scan(rand_scan());
        checks++;
        if (frame_valid !== 1'b1 || exp_frame_q.size() != 1 || frame_digits !== exp_frame_q[0]) begin
            failures++; $display("FAIL ovr_first: got %b/%h expected 1/%h", frame_valid, frame_digits, exp_frame_q[0]);
        end
        held = exp_frame_q[0];
        send_scan(rand_scan());
        checks++;
        if (frame_valid !== 1'b1 || frame_digits !== held) begin
            failures++; $display("FAIL ovr_hold: got %b/%h expected 1/%h", frame_valid, frame_digits, held);
        end
        checks++;
        if (ovr_seen - o0 != 1) begin
            failures++; $display("FAIL ovr_pulse: got %0d expected 1", ovr_seen - o0);
        end
        frame_ready = 1'b1;
        tick();
        checks++;
        if (frame_valid !== 1'b0 || got_frame_q.size() != 1 || got_frame_q[0] !== held) begin
            failures++; $display("FAIL ovr_accept: got valid=%b n=%0d expected 0/1", frame_valid, got_frame_q.size());
        end
    endtask

    task automatic test_code_err();
        logic [31:0] d;
        int e0;
        clear_queues();
        e0 = err_seen;
        exp_err = 0;
        d = rand_scan();
        for (int n = 0; n < 8; n++) begin
            if (n == 3) send_epoch(8'h80 >> n, 8'h12, 8);
            else send_digit(n, d[31 - 4 * n -: 4]);
        end
        d = rand_scan();
        for (int n = 0; n < 8; n++) begin
            if (n == 5) send_epoch(8'h11, pat_tbl[d[31 - 4 * n -: 4]], 8);
            else send_digit(n, d[31 - 4 * n -: 4]);
        end
        checks++;
        if (err_seen - e0 != 2 || exp_err != 2) begin
            failures++; $display("FAIL err_count: got %0d expected 2", err_seen - e0);
        end
        checks++;
        if (got_frame_q.size() != 1) begin
            failures++; $display("FAIL err_frames: got %0d expected 1", got_frame_q.size());
        end else begin
            checks++;
            if (got_frame_q[0][19:16] !== 4'hF || got_frame_q[0] !== exp_frame_q[0]) begin
                failures++; $display("FAIL err_digit3: got %h expected %h", got_frame_q[0], exp_frame_q[0]);
            end
        end
    endtask

    task automatic test_back_to_back();
        clear_queues();
        for (int s = 0; s < 6; s++) send_scan(rand_scan());
        checks++;
        if (got_frame_q.size() != 6 || exp_frame_q.size() != 6) begin
            failures++; $display("FAIL b2b_count: got %0d expected 6", got_frame_q.size());
        end else begin
            for (int i = 0; i < 6; i++) begin
                checks++;
                if (got_frame_q[i] !== exp_frame_q[i] || got_mask_q[i] !== exp_mask_q[i]) begin
                    failures++; $display("FAIL b2b_frame%0d: got %h expected %h", i, got_frame_q[i], exp_frame_q[i]);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        logic [31:0] d;
        clear_queues();
        d = rand_scan();
        for (int n = 0; n < 4; n++) send_digit(n, d[31 - 4 * n -: 4]);
        seg_which = 8'h08; seg_data = pat_tbl[d[11:8]];
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
        model_reset();
        for (int n = 4; n < 8; n++) send_digit(n, d[31 - 4 * n -: 4]);
        checks++;
        if (got_frame_q.size() != 0 || frame_valid !== 1'b0) begin
            failures++; $display("FAIL rstmid_partial: got %0d frames expected 0", got_frame_q.size());
        end
        send_scan(rand_scan());
        checks++;
        if (got_frame_q.size() != 1 || exp_frame_q.size() != 1 || got_frame_q[0] !== exp_frame_q[0]) begin
            failures++; $display("FAIL rstmid_next: got %0d frames expected 1 matching", got_frame_q.size());
        end
    endtask

    task automatic test_stale();
        send_scan(rand_scan());
        repeat (194) tick();
        checks++;
        if (stale !== 1'b0) begin
            failures++; $display("FAIL stale_early: got %b expected 0", stale);
        end
        tick();
        checks++;
        if (stale !== STALE_ON) begin
            failures++; $display("FAIL stale_set: got %b expected %b", stale, STALE_ON);
        end
        send_scan(rand_scan());
        checks++;
        if (stale !== 1'b0) begin
            failures++; $display("FAIL stale_clear: got %b expected 0", stale);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_blank();
        test_overrun();
        test_code_err();
        test_back_to_back();
        test_reset_mid();
        test_stale();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
